// File: rtl/serial_cla_adder.sv
// Serial adder: one 4-bit carry-lookahead slice per cycle, IDLE/CALC/DONE valid-ready handshake.
// Optional signed-overflow output is enabled by defining SERIAL_CLA_OVF_EN.
module serial_cla_adder #(
  parameter int NIBBLES = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [4*NIBBLES-1:0] a,
  input  logic [4*NIBBLES-1:0] b,
  input  logic                 cin,
  output logic [4*NIBBLES-1:0] sum,
  output logic                 cout,
`ifdef SERIAL_CLA_OVF_EN
  output logic                 ovf,
`endif
  output logic                 out_valid,
  input  logic                 out_ready
);

  localparam int W    = 4 * NIBBLES;
  localparam int IDXW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t           r_state;
  state_t           w_next;
  logic [W-1:0]     r_a;
  logic [W-1:0]     r_b;
  logic [W-1:0]     r_sum;
  logic [IDXW-1:0]  r_idx;
  logic             r_carry;
  logic             r_cout;
  logic [3:0]       w_a_nib;
  logic [3:0]       w_b_nib;
  logic [3:0]       w_slice_sum;
  logic             w_slice_cout;
  logic             w_last;
  logic             w_accept;
`ifdef SERIAL_CLA_OVF_EN
  logic             r_ovf;
`endif

  // Single 4-bit slice with fully expanded lookahead carries; returns {carry_out, sum}.
  function automatic logic [4:0] carry_lookahead_adder(input logic [3:0] x,
                                                       input logic [3:0] y,
                                                       input logic       ci);
    logic [3:0] g;
    logic [3:0] p;
    logic [4:0] c;
    g    = x & y;
    p    = x ^ y;
    c[0] = ci;
    c[1] = g[0] | (p[0] & ci);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
    c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & ci);
    return {c[4], p ^ c[3:0]};
  endfunction

  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state == DONE);
  assign w_accept  = in_valid && (r_state == IDLE);
  assign w_last    = (r_idx == IDXW'(NIBBLES - 1));
  assign sum       = r_sum;
  assign cout      = r_cout;
`ifdef SERIAL_CLA_OVF_EN
  assign ovf       = r_ovf;
`endif

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (in_valid)  w_next = CALC;
      CALC:    if (w_last)    w_next = DONE;
      DONE:    if (out_ready) w_next = IDLE;
      default:                w_next = IDLE;
    endcase
  end

  // Select the operand nibbles addressed by the current slice index.
  always_comb begin
    w_a_nib = 4'h0;
    w_b_nib = 4'h0;
    for (int n = 0; n < NIBBLES; n++) begin
      if (r_idx == IDXW'(n)) begin
        w_a_nib = r_a[4*n +: 4];
        w_b_nib = r_b[4*n +: 4];
      end
    end
    {w_slice_cout, w_slice_sum} = carry_lookahead_adder(w_a_nib, w_b_nib, r_carry);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
      r_idx   <= '0;
      r_carry <= 1'b0;
      r_cout  <= 1'b0;
`ifdef SERIAL_CLA_OVF_EN
      r_ovf   <= 1'b0;
`endif
    end else if (w_accept) begin
      r_a     <= a;
      r_b     <= b;
      r_carry <= cin;
      r_idx   <= '0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
`ifdef SERIAL_CLA_OVF_EN
      r_ovf   <= 1'b0;
`endif
    end else if (r_state == CALC) begin
      for (int n = 0; n < NIBBLES; n++) begin
        if (r_idx == IDXW'(n)) r_sum[4*n +: 4] <= w_slice_sum;
      end
      r_carry <= w_slice_cout;
      r_idx   <= w_last ? '0 : r_idx + IDXW'(1);
      // Flags are captured on the last slice so they are stable for all of DONE.
      if (w_last) begin
        r_cout <= w_slice_cout;
`ifdef SERIAL_CLA_OVF_EN
        r_ovf  <= (r_a[W-1] == r_b[W-1]) && (w_slice_sum[3] != r_a[W-1]);
`endif
      end
    end
  end

endmodule

// File: tb/tb_serial_cla_adder.sv
// Self-checking bench for serial_cla_adder (NIBBLES = 4) with a result scoreboard.
// Overflow checks are compiled in only when SERIAL_CLA_OVF_EN is defined.
module tb_serial_cla_adder;

  localparam int W = 16;

  typedef struct packed {
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic [W-1:0] sum;
  logic         cout;
  logic         out_valid;
  logic         out_ready;
`ifdef SERIAL_CLA_OVF_EN
  logic         ovf;
`endif

  exp_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;

  serial_cla_adder #(.NIBBLES(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .sum       (sum),
    .cout      (cout),
`ifdef SERIAL_CLA_OVF_EN
    .ovf       (ovf),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  // Reference result from a single full-width addition of the operands.
  function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y, input logic ci);
    exp_t         e;
    logic [W:0]   full;
    full   = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, ci};
    e.sum  = full[W-1:0];
    e.cout = full[W];
    e.ovf  = (x[W-1] == y[W-1]) && (full[W-1] != x[W-1]);
    return e;
  endfunction

  // Drives one operation through the input handshake and pushes its expected result.
  task automatic send_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic ci);
    a        = x;
    b        = y;
    cin      = ci;
    in_valid = 1'b1;
    sb.push_back(model(x, y, ci));
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Counts edges after the handshake until out_valid, bounded to avoid hangs.
  task automatic wait_result(output int lat);
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; cin = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    vectors++; if (sum !== 16'h0000) begin miscompares++; $display("[TB] FAIL reset_sum: got %h expected 0000", sum); end
    vectors++; if (cout !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_cout: got %b expected 0", cout); end
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_out_valid: got %b expected 0", out_valid); end
    vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL reset_in_ready: got %b expected 1", in_ready); end
`ifdef SERIAL_CLA_OVF_EN
    vectors++; if (ovf !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_ovf: got %b expected 0", ovf); end
`endif
  endtask

  // One full operation: latency, result fields, then release back to IDLE.
  task automatic test_add(input string name, input logic [W-1:0] x, input logic [W-1:0] y, input logic ci);
    int   lat;
    exp_t e;
    send_op(x, y, ci);
    vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("[TB] FAIL %s_busy_in_ready: got %b expected 0", name, in_ready); end
    wait_result(lat);
    e = sb.pop_front();
    vectors++; if (lat != 4) begin miscompares++; $display("[TB] FAIL %s_latency: got %0d expected 4", name, lat); end
    vectors++; if (sum !== e.sum) begin miscompares++; $display("[TB] FAIL %s_sum: got %h expected %h", name, sum, e.sum); end
    vectors++; if (cout !== e.cout) begin miscompares++; $display("[TB] FAIL %s_cout: got %b expected %b", name, cout, e.cout); end
`ifdef SERIAL_CLA_OVF_EN
    vectors++; if (ovf !== e.ovf) begin miscompares++; $display("[TB] FAIL %s_ovf: got %b expected %b", name, ovf, e.ovf); end
`endif
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    vectors++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL %s_release: got out_valid=%b in_ready=%b expected 0/1", name, out_valid, in_ready); end
    vectors++; if (sum !== e.sum) begin miscompares++; $display("[TB] FAIL %s_sum_hold: got %h expected %h", name, sum, e.sum); end
  endtask

  // Operand changes during CALC and DONE must be ignored; result holds under backpressure.
  task automatic test_backpressure;
    int   lat;
    exp_t e;
    send_op(16'h0F0F, 16'h1111, 1'b1);
    in_valid = 1'b1; a = 16'hAAAA; b = 16'h5555; cin = 1'b1;
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    e = sb.pop_front();
    vectors++; if (lat != 4) begin miscompares++; $display("[TB] FAIL bp_latency: got %0d expected 4", lat); end
    for (int i = 0; i < 5; i++) begin
      in_valid = i[0]; a = 16'hFFFF - 16'(i); b = 16'(i * 3);
      vectors++; if (sum !== e.sum || cout !== e.cout) begin miscompares++; $display("[TB] FAIL bp_hold_%0d: got %h/%b expected %h/%b", i, sum, cout, e.sum, e.cout); end
      vectors++; if (out_valid !== 1'b1 || in_ready !== 1'b0) begin miscompares++; $display("[TB] FAIL bp_flags_%0d: got out_valid=%b in_ready=%b expected 1/0", i, out_valid, in_ready); end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    vectors++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL bp_release: got out_valid=%b in_ready=%b expected 0/1", out_valid, in_ready); end
    vectors++; if (sum !== e.sum) begin miscompares++; $display("[TB] FAIL bp_sum_after: got %h expected %h", sum, e.sum); end
  endtask

  // Reset two edges after the handshake abandons the op; out_ready held high meanwhile.
  task automatic test_reset_mid_op;
    a = 16'hFFFF; b = 16'h0001; cin = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    vectors++; if (sum !== 16'h0000 || cout !== 1'b0) begin miscompares++; $display("[TB] FAIL rstmid_outputs: got %h/%b expected 0000/0", sum, cout); end
    vectors++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL rstmid_flags: got in_ready=%b out_valid=%b expected 1/0", in_ready, out_valid); end
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL rstmid_no_pulse_%0d: got %b expected 0", i, out_valid); end
    end
    out_ready = 1'b0;
    test_add("post_rst", 16'h1234, 16'h4321, 1'b0);
  endtask

  // Continuous traffic with out_ready=1: scoreboard ordering and N+2 cycle period.
  task automatic test_back_to_back;
    int   cyc = 0;
    int   last_hs = -1;
    int   n_sent = 0;
    int   n_done = 0;
    logic hs;
    logic ov;
    exp_t e;
    out_ready = 1'b1;
    a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom); in_valid = 1'b1;
    while (n_done < 5 && cyc < 100) begin
      hs = in_valid && in_ready;
      ov = out_valid;
      if (ov) begin
        if (sb.size() == 0) begin
          vectors++; miscompares++; $display("[TB] FAIL b2b_unexpected: got result %h expected none", sum);
        end else begin
          e = sb.pop_front();
          vectors++; if (sum !== e.sum || cout !== e.cout) begin miscompares++; $display("[TB] FAIL b2b_result_%0d: got %h/%b expected %h/%b", n_done, sum, cout, e.sum, e.cout); end
        end
        n_done++;
      end
      if (hs) sb.push_back(model(a, b, cin));
      @(posedge clk); #1;
      cyc++;
      if (hs) begin
        if (last_hs >= 0) begin
          vectors++; if (cyc - last_hs != 6) begin miscompares++; $display("[TB] FAIL b2b_period: got %0d expected 6", cyc - last_hs); end
        end
        last_hs = cyc;
        n_sent++;
        if (n_sent < 5) begin
          a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom);
        end else begin
          in_valid = 1'b0;
        end
      end
    end
    vectors++; if (n_done != 5) begin miscompares++; $display("[TB] FAIL b2b_timeout: got %0d results expected 5", n_done); end
    in_valid = 1'b0;
    out_ready = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset;
    @(posedge clk); #1;
    test_add("small", 16'h0001, 16'h0002, 1'b0);
    test_add("carry_chain", 16'hFFFF, 16'hFFFF, 1'b1);
    test_add("overflow", 16'h7FFF, 16'h0001, 1'b0);
    test_add("neg_ovf", 16'h8000, 16'h8000, 1'b0);
    test_add("mixed", 16'h89AB, 16'h7654, 1'b1);
    test_backpressure;
    test_reset_mid_op;
    test_back_to_back;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/serial_cla_adder.md
SERIAL_CLA_ADDER -- requirements
Module: serial_cla_adder

Interface
REQ-001 Parameter NIBBLES, default 4, SHALL set the number of 4-bit slices; operand width W = 4*NIBBLES; legal range 1..8.
REQ-002 Port clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 Port rst  input  1  SHALL be the reset: synchronous, active-high.
REQ-004 Port in_valid  input  1  SHALL flag that a, b and cin hold a valid operation.
REQ-005 Port in_ready  output  1  SHALL flag that the block accepts an operation this cycle.
REQ-006 Port a  input  W  SHALL be operand A, unsigned or two's complement.
REQ-007 Port b  input  W  SHALL be operand B.
REQ-008 Port cin  input  1  SHALL be the carry into bit 0.
REQ-009 Port sum  output  W  SHALL be the result (a + b + cin) mod 2^W.
REQ-010 Port cout  output  1  SHALL be the carry out of bit W-1.
REQ-011 Port out_valid  output  1  SHALL flag that sum and cout (and ovf) are valid.
REQ-012 Port out_ready  input  1  SHALL flag that the consumer takes the result this cycle.
REQ-013 Port ovf  output  1  SHALL be the signed-overflow flag; it SHALL exist only when SERIAL_CLA_OVF_EN is defined.

Function
REQ-014 The block SHALL have exactly three states: IDLE, CALC and DONE.
REQ-015 In IDLE, in_ready SHALL be 1; in CALC and DONE it SHALL be 0.
REQ-016 An input handshake SHALL be in_valid && in_ready at a rising edge.
  - On that edge the block SHALL latch a, b and cin.
  - It SHALL clear the nibble index and the sum register.
  - It SHALL enter CALC.
REQ-017 Each CALC cycle SHALL add nibble[idx] of A and B plus the registered carry using one 4-bit carry_lookahead_adder slice.
  - The 4-bit result SHALL be written into sum[4*idx+3:4*idx].
  - The slice carry-out SHALL be written into the carry register.
  - idx SHALL increment.
REQ-018 The carry register SHALL load cin on the input handshake, so nibble 0 uses cin.
REQ-019 After the CALC cycle with idx = NIBBLES-1, the block SHALL enter DONE.
  - cout SHALL equal the final slice carry.
  - out_valid SHALL be 1 exactly NIBBLES edges after the handshake edge.
REQ-020 In DONE, sum, cout, ovf and out_valid SHALL hold stable until out_ready = 1 at a rising edge.
  - On that edge out_valid SHALL drop to 0 and the block SHALL return to IDLE.
  - sum and cout SHALL keep their values until the next handshake.
REQ-021 in_valid asserted in CALC or DONE SHALL be ignored and SHALL NOT corrupt latched operands.
REQ-022 out_ready asserted outside DONE SHALL have no effect.
REQ-023 Operations SHALL NOT overlap. The minimum period per operation SHALL be NIBBLES+2 cycles when out_ready is held at 1.
REQ-024 With NIBBLES = 1, the block SHALL perform one CALC cycle and otherwise behave identically.
REQ-025 Outputs in_ready and out_valid SHALL be decoded from the state register only, with no combinational path from any input.

Reset
REQ-026 While rst = 1 at a rising edge, the block SHALL enter IDLE.
  - Sum, cout, ovf, out_valid, idx and the carry register SHALL be 0.
  - in_ready SHALL be 1 from the following cycle.
REQ-027 Reset asserted in CALC or DONE SHALL abandon the operation, with no out_valid pulse for it.
REQ-028 rst SHALL take priority over a coincident input or output handshake.

Configuration
REQ-029 With macro SERIAL_CLA_OVF_EN defined, port ovf SHALL be present. It SHALL be set at DONE entry to (a[W-1] == b[W-1]) && (sum[W-1] != a[W-1]).
REQ-030 Without SERIAL_CLA_OVF_EN, port ovf and its logic SHALL be absent; all other behaviour SHALL be identical.

Verification (NIBBLES = 4)
REQ-031 Reset scenario: hold rst 2 cycles -> sum=0x0000, cout=0, out_valid=0, in_ready=1.
REQ-032 Small add: a=0x0001, b=0x0002, cin=0 -> out_valid 4 edges after the handshake; sum=0x0003, cout=0, ovf=0.
REQ-033 Full carry chain: a=0xFFFF, b=0xFFFF, cin=1 -> sum=0xFFFF, cout=1, ovf=0.
REQ-034 Signed overflow: a=0x7FFF, b=0x0001, cin=0 -> sum=0x8000, cout=0, ovf=1 with the macro defined.
REQ-035 Backpressure: hold out_ready=0 for 5 cycles in DONE and pulse in_valid with new operands.
  - Result SHALL stay stable and in_ready SHALL stay 0.
  - The new operands SHALL be ignored.
  - Raising out_ready SHALL return the block to IDLE on the next edge.
REQ-036 Reset mid-operation: assert rst 2 cycles after the handshake -> IDLE, outputs 0, no out_valid pulse; a following operation a=0x1234, b=0x4321, cin=0 SHALL give sum=0x5555.
